sha_2_padder: RTL and testbench
===============================

SHA_2_PADDER -- requirements
Module: sha_2_padder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning input word width in bits; legal values are 32, 64, 128, 256 and 512.
REQ-002 The block SHALL have parameter LEN_W, default 64, meaning message-length field width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port cfg_size, input, LEN_W bits: message length in bits, always a multiple of 8.
REQ-006 The block SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): valid/ready handshake for cfg_size.
REQ-007 The block SHALL have port data_in, input, DATA_W bits: message word, first byte in the MSBs.
REQ-008 The block SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1): valid/ready handshake for data_in.
REQ-009 The block SHALL have port block_out, output, 512 bits: padded SHA-2 block, first byte in the MSBs.
REQ-010 The block SHALL have ports block_valid (output, 1), block_ready (input, 1) and block_last (output, 1); block_last marks the final block of a message.

Function
REQ-011 The block SHALL implement the states IDLE, COLLECT, EMIT and PAD.
REQ-012 cfg_ready SHALL be 1 only in IDLE; a cfg handshake SHALL latch cfg_size, clear the block buffer, load remaining-bits with cfg_size and move to COLLECT on the next cycle.
REQ-013 data_in_ready SHALL be 1 only in COLLECT while remaining-bits > 0 and the buffer holds fewer than 512/DATA_W words.
REQ-014 Each accepted word SHALL be written into the next DATA_W slot from the MSB; remaining-bits SHALL decrease by min(DATA_W, remaining-bits), saturating at 0.
REQ-015 Bits of the final word beyond cfg_size SHALL be ignored and forced to 0.
REQ-016 COLLECT SHALL move to EMIT when the buffer is full or remaining-bits reaches 0; block_valid SHALL rise on the cycle after the last accepted word.
REQ-017 For the block in which the message ends, bit offset r = cfg_size mod 512: byte r/8 SHALL be 0x80 when r < 512 within the block, and every later byte SHALL be 0.
REQ-018 If r <= 440 and the message ends in that block, the low 64 bits SHALL hold cfg_size and block_last SHALL be 1.
REQ-019 If r > 440, or r = 0 with cfg_size > 0, EMIT SHALL be followed by PAD: block_last = 0 on the data block, then one PAD block with low 64 bits = cfg_size and block_last = 1.
REQ-020 In the PAD block, the MSB byte SHALL be 0x80 only when r = 0; otherwise the block SHALL be all zeros except the length field.
REQ-021 cfg_size = 0 SHALL skip data accept and emit one block {0x80, zeros, 64'd0} with block_last = 1.
REQ-022 block_out, block_valid and block_last SHALL be registered and SHALL stay stable while block_valid = 1 and block_ready = 0.
REQ-023 A block handshake SHALL go EMIT->COLLECT (non-final data block), EMIT/PAD->PAD (as REQ-019), or the last block->IDLE.
REQ-024 No data_in or cfg handshake SHALL occur while block_valid = 1.
REQ-025 Words presented on data_in outside COLLECT SHALL be neither accepted nor corrupted.

Reset
REQ-026 While nrst = 0: state = IDLE; block_valid, block_last, data_in_ready = 0; block_out, buffer, counters = 0; cfg_ready = 1 from the first cycle after release.
REQ-027 Reset asserted mid-message SHALL discard all partial data; the first post-reset block SHALL belong to a new cfg.

Structure
REQ-028 Package sha_2_pkg SHALL hold the state enum, BLOCK_W = 512, LEN_FIELD_W = 64 and PAD_BYTE = 8'h80.
REQ-029 The byte-mask/pad insertion SHALL be a package function; no sub-module is required; target size is 150-300 RTL lines.

Verification
REQ-030 DATA_W=32, cfg_size=24, word 0x61626300 -> one block 0x61626380, zeros, low 64 bits = 0x18, block_last=1, valid one cycle after accept.
REQ-031 cfg_size=448 (14 words) -> block 1: data, 0x80 at byte 56, block_last=0; block 2: zeros, length 0x1C0, block_last=1.
REQ-032 cfg_size=512, DATA_W=512 -> data block with block_last=0, then 0x80 MSB byte, zeros, length 0x200, block_last=1.
REQ-033 cfg_size=0 -> single block 0x80 followed by zeros, length 0, no data_in_ready pulse.
REQ-034 block_ready held 0 for 5 cycles during EMIT -> block_out/block_last unchanged, data_in_ready=0, cfg_ready=0.
REQ-035 nrst pulsed after 3 of 16 words -> all outputs at reset values; a new cfg_size=24 message yields exactly the REQ-030 block.

Source files
------------

// File: rtl/sha_2_pkg.sv
// -----------------------------------------------------------------------------
// sha_2_pkg
// Shared definitions for the SHA-2 message padder.
//   BLOCK_W      : width of one SHA-2 message block (512 bits)
//   LEN_FIELD_W  : width of the trailing message-length field (64 bits)
//   PAD_BYTE     : the 0x80 marker appended right after the last message byte
//   state_e      : padder FSM states
//   pad_block()  : applies end-of-message byte masking, the 0x80 marker and the
//                  length field to a 512-bit block
// -----------------------------------------------------------------------------
package sha_2_pkg;

    localparam int         BLOCK_W     = 512;
    localparam int         LEN_FIELD_W = 64;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    // Largest in-block bit offset that still leaves room for the 0x80 byte
    // and the 64-bit length field in the same block (512 - 64 - 8).
    localparam int         LEN_MAX_R   = BLOCK_W - LEN_FIELD_W - 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EMIT,
        ST_PAD
    } state_e;

    // cut     : place PAD_BYTE at byte r/8 and zero every later byte
    // add_len : overwrite the low LEN_FIELD_W bits with len
    // Byte 0 is the MSB byte of the block.
    function automatic logic [BLOCK_W-1:0] pad_block(
        input logic [BLOCK_W-1:0]     data,
        input logic [8:0]             r,
        input logic                   cut,
        input logic                   add_len,
        input logic [LEN_FIELD_W-1:0] len
    );
        logic [BLOCK_W-1:0] blk;
        blk = data;
        if (cut) begin
            for (int i = 0; i < BLOCK_W / 8; i++) begin
                if (i == int'(r[8:3])) begin
                    blk[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
                end else if (i > int'(r[8:3])) begin
                    blk[BLOCK_W-1-8*i -: 8] = 8'h00;
                end
            end
        end
        if (add_len) begin
            blk[LEN_FIELD_W-1:0] = len;
        end
        return blk;
    endfunction

endpackage

// File: rtl/sha_2_padder.sv
// -----------------------------------------------------------------------------
// sha_2_padder
// Collects a message of cfg_size bits (arriving as DATA_W-bit words, first
// byte in the MSBs) into 512-bit blocks and applies SHA-2 padding: a 0x80
// byte after the message, zero fill and the 64-bit message length. An extra
// length-only block is emitted when the final data block has no room left.
//
// Ports
//   clk, nrst        : clock (rising edge), asynchronous active-low reset
//   cfg_size         : message length in bits (multiple of 8)
//   cfg_valid/ready  : handshake for cfg_size, ready only when idle
//   data_in          : message word
//   data_in_valid/ready : handshake for data_in
//   block_out        : registered padded block, first byte in the MSBs
//   block_valid/ready: handshake for block_out
//   block_last       : marks the final block of the message
// -----------------------------------------------------------------------------
module sha_2_padder
    import sha_2_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 64
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [LEN_W-1:0]   cfg_size,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    output logic [BLOCK_W-1:0] block_out,
    output logic               block_valid,
    input  logic               block_ready,
    output logic               block_last
);

    localparam int WORDS = BLOCK_W / DATA_W;
    localparam int CNT_W = $clog2(WORDS + 1);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cfg_q, cfg_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               need_pad_q, need_pad_d;

    logic                   cfg_hs, in_hs, blk_hs;
    logic [LEN_W-1:0]       rem_sub;
    logic                   last_word;
    logic                   load_blk;
    logic [8:0]             r;
    logic                   full_tail;
    logic [LEN_FIELD_W-1:0] len_field;
    logic                   ends;

    assign cfg_hs = cfg_valid && cfg_ready;
    assign in_hs  = data_in_valid && data_in_ready;
    assign blk_hs = valid_q && block_ready;

    // Remaining bits after one more word, saturating at zero.
    assign rem_sub   = (rem_q > LEN_W'(DATA_W)) ? rem_q - LEN_W'(DATA_W) : '0;
    assign last_word = (cnt_q == CNT_W'(WORDS - 1));

    // The block is captured on the edge that accepts the word completing it,
    // so block_valid rises the cycle after that word. An empty message
    // arrives in COLLECT with nothing to accept and is captured at once.
    assign load_blk = (state_q == ST_COLLECT) &&
                      ((in_hs && (last_word || rem_sub == '0)) || rem_q == '0);

    assign r         = cfg_q[8:0];
    // Message fills its last block exactly: the 0x80 moves to the PAD block.
    assign full_tail = (r == 9'd0) && (cfg_q != '0);
    assign len_field = LEN_FIELD_W'(cfg_q);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: asynchronous reset clears every register, the block buffer
    // included, so no fragment of an interrupted message can leak out later.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (cfg_hs)   state_d = ST_COLLECT;
            ST_COLLECT: if (load_blk) state_d = ST_EMIT;
            ST_EMIT: begin
                if (blk_hs) begin
                    if (last_q)          state_d = ST_IDLE;
                    else if (need_pad_q) state_d = ST_PAD;
                    else                 state_d = ST_COLLECT;
                end
            end
            ST_PAD:     if (blk_hs)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_ready     = (state_q == ST_IDLE);
        data_in_ready = (state_q == ST_COLLECT) && (rem_q != '0) &&
                        (cnt_q < CNT_W'(WORDS));
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_d      = cfg_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        block_d    = block_q;
        valid_d    = valid_q;
        last_d     = last_q;
        need_pad_d = need_pad_q;
        ends       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_hs) begin
                    cfg_d = cfg_size;
                    rem_d = cfg_size;
                    cnt_d = '0;
                    buf_d = '0;
                end
            end
            ST_COLLECT: begin
                if (in_hs) begin
                    for (int s = 0; s < WORDS; s++) begin
                        if (cnt_q == CNT_W'(s)) begin
                            buf_d[BLOCK_W-1-s*DATA_W -: DATA_W] = data_in;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    rem_d = rem_sub;
                end
                if (load_blk) begin
                    ends       = (rem_d == '0);
                    // Tail bits beyond cfg_size are cleared by the byte cut.
                    block_d    = pad_block(buf_d, r, ends && !full_tail,
                                           ends && !full_tail && (r <= 9'(LEN_MAX_R)),
                                           len_field);
                    valid_d    = 1'b1;
                    last_d     = ends && !full_tail && (r <= 9'(LEN_MAX_R));
                    need_pad_d = ends && !(!full_tail && (r <= 9'(LEN_MAX_R)));
                end
            end
            ST_EMIT: begin
                if (blk_hs) begin
                    // Next data block starts from a clean buffer so a short
                    // final block never carries words of the previous one.
                    cnt_d = '0;
                    buf_d = '0;
                    if (!last_q && need_pad_q) begin
                        block_d = pad_block('0, r, (r == 9'd0), 1'b1, len_field);
                        last_d  = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                    need_pad_d = 1'b0;
                end
            end
            ST_PAD: begin
                if (blk_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            block_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            need_pad_q <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            block_q    <= block_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            need_pad_q <= need_pad_d;
        end
    end

    assign block_out   = block_q;
    assign block_valid = valid_q;
    assign block_last  = last_q;

endmodule

// File: tb/tb_sha_2_padder.sv
// -----------------------------------------------------------------------------
// tb_sha_2_padder
// Directed vectors with hand-built expected blocks pushed into per-DUT queues;
// monitors pop and compare on each block handshake. One DUT with DATA_W=32 and
// one with DATA_W=512.
// -----------------------------------------------------------------------------
module tb_sha_2_padder;

    localparam int BUDGET = 200;

    typedef struct {
        logic [511:0] blk;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // DATA_W = 32 instance
    logic [63:0]  cfg_size;
    logic         cfg_valid, cfg_ready;
    logic [31:0]  data_in;
    logic         data_in_valid, data_in_ready;
    logic [511:0] block_out;
    logic         block_valid, block_ready, block_last;

    // DATA_W = 512 instance
    logic [63:0]  w_cfg_size;
    logic         w_cfg_valid, w_cfg_ready;
    logic [511:0] w_data_in;
    logic         w_data_in_valid, w_data_in_ready;
    logic [511:0] w_block_out;
    logic         w_block_valid, w_block_ready, w_block_last;

    sha_2_padder #(.DATA_W(32), .LEN_W(64)) dut32 (
        .clk(clk), .nrst(nrst),
        .cfg_size(cfg_size), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .block_out(block_out), .block_valid(block_valid),
        .block_ready(block_ready), .block_last(block_last)
    );

    sha_2_padder #(.DATA_W(512), .LEN_W(64)) dut512 (
        .clk(clk), .nrst(nrst),
        .cfg_size(w_cfg_size), .cfg_valid(w_cfg_valid), .cfg_ready(w_cfg_ready),
        .data_in(w_data_in), .data_in_valid(w_data_in_valid), .data_in_ready(w_data_in_ready),
        .block_out(w_block_out), .block_valid(w_block_valid),
        .block_ready(w_block_ready), .block_last(w_block_last)
    );

    int    tests = 0;
    int    fails = 0;
    string tname = "reset";
    exp_t  q32[$];
    exp_t  q512[$];
    exp_t  e, m32, m512;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no handshake within %0d cycles", name, BUDGET);
    endtask

    // Scoreboard monitors: compare at the falling edge when a handshake is due.
    always @(negedge clk) begin
        if (nrst && block_valid && block_ready) begin
            if (q32.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s_extra32: got unexpected block %h", tname, block_out);
            end else begin
                m32 = q32.pop_front();
                check({tname, "_blk"}, block_out, m32.blk);
                check({tname, "_last"}, 512'(block_last), 512'(m32.last));
            end
        end
    end

    always @(negedge clk) begin
        if (nrst && w_block_valid && w_block_ready) begin
            if (q512.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s_extra512: got unexpected block %h", tname, w_block_out);
            end else begin
                m512 = q512.pop_front();
                check({tname, "_wblk"}, w_block_out, m512.blk);
                check({tname, "_wlast"}, 512'(w_block_last), 512'(m512.last));
            end
        end
    end

    task automatic cfg32(input logic [63:0] size);
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_size  = size;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (cfg_ready) break;
            if (n == BUDGET) begin timeout({tname, "_cfg"}); break; end
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic word32(input logic [31:0] w);
        data_in_valid = 1'b1;
        data_in       = w;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (data_in_ready) break;
            if (n == BUDGET) begin timeout({tname, "_word"}); break; end
        end
        @(posedge clk); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic msg512(input logic [63:0] size, input logic [511:0] w);
        @(posedge clk); #1;
        w_cfg_valid = 1'b1;
        w_cfg_size  = size;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (w_cfg_ready) break;
            if (n == BUDGET) begin timeout({tname, "_wcfg"}); break; end
        end
        @(posedge clk); #1;
        w_cfg_valid     = 1'b0;
        w_data_in_valid = 1'b1;
        w_data_in       = w;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (w_data_in_ready) break;
            if (n == BUDGET) begin timeout({tname, "_wword"}); break; end
        end
        @(posedge clk); #1;
        w_data_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < BUDGET; n++) begin
            if (q32.size() == 0 && q512.size() == 0) return;
            @(negedge clk);
        end
        timeout({tname, "_drain"});
        q32.delete();
        q512.delete();
    endtask

    // The abc block: 0x61626380, zeros, length 24.
    task automatic push_abc();
        e.blk          = '0;
        e.blk[511:480] = 32'h6162_6380;
        e.blk[63:0]    = 64'd24;
        e.last         = 1'b1;
        q32.push_back(e);
    endtask

    logic [511:0] wide;
    logic [511:0] stall_blk;
    int           pulses;

    initial begin
        nrst            = 1'b0;
        cfg_size        = '0;  cfg_valid   = 1'b0;
        data_in         = '0;  data_in_valid = 1'b0;
        block_ready     = 1'b1;
        w_cfg_size      = '0;  w_cfg_valid = 1'b0;
        w_data_in       = '0;  w_data_in_valid = 1'b0;
        w_block_ready   = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 512'(block_valid), 512'(0));
        check("rst_last", 512'(block_last), 512'(0));
        check("rst_din_ready", 512'(data_in_ready), 512'(0));
        check("rst_block_out", block_out, '0);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;
        check("rst_cfg_ready", 512'(cfg_ready), 512'(1));
        check("rst_wcfg_ready", 512'(w_cfg_ready), 512'(1));

        // 24-bit message, valid one cycle after the accepting edge
        tname = "abc";
        push_abc();
        cfg32(64'd24);
        word32(32'h6162_6300);
        check("abc_latency", 512'(block_valid), 512'(1));
        wait_drain();

        // Bits beyond cfg_size in the final word are dropped
        tname = "mask";
        push_abc();
        cfg32(64'd24);
        word32(32'h6162_63FF);
        wait_drain();

        // 448 bits: 0x80 at byte 56, no room for length -> PAD block
        tname = "m448";
        e.blk = '0;
        for (int i = 0; i < 14; i++) e.blk[511-32*i -: 32] = 32'h0101_0101 * (i + 1);
        e.blk[63:56] = 8'h80;
        e.last = 1'b0;
        q32.push_back(e);
        e.blk = '0;
        e.blk[63:0] = 64'h1C0;
        e.last = 1'b1;
        q32.push_back(e);
        cfg32(64'd448);
        for (int i = 0; i < 14; i++) word32(32'h0101_0101 * (i + 1));
        wait_drain();

        // Empty message: no data accept, {0x80, zeros, 0}
        tname = "empty";
        e.blk = '0;
        e.blk[511:504] = 8'h80;
        e.last = 1'b1;
        q32.push_back(e);
        cfg32(64'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_in_ready) pulses++;
            if (block_valid) break;
        end
        check("empty_no_din_ready", 512'(pulses), 512'(0));
        wait_drain();

        // 544 bits: full data block, then a short block that must not reuse
        // stale words; 0x80 at byte 4 and length 0x220
        tname = "m544";
        e.blk = '0;
        for (int i = 0; i < 16; i++) e.blk[511-32*i -: 32] = 32'hC0DE_0000 | i;
        e.last = 1'b0;
        q32.push_back(e);
        e.blk = '0;
        e.blk[511:480] = 32'hC0DE_0010;
        e.blk[479:472] = 8'h80;
        e.blk[63:0]    = 64'h220;
        e.last = 1'b1;
        q32.push_back(e);
        cfg32(64'd544);
        for (int i = 0; i < 17; i++) word32(32'hC0DE_0000 | i);
        wait_drain();

        // 512 bits on the 512-bit instance: data block, then 0x80 + length
        tname = "w512";
        wide = {16{32'hDEAD_BEEF}};
        e.blk  = wide;
        e.last = 1'b0;
        q512.push_back(e);
        e.blk = '0;
        e.blk[511:504] = 8'h80;
        e.blk[63:0]    = 64'h200;
        e.last = 1'b1;
        q512.push_back(e);
        msg512(64'd512, wide);
        wait_drain();

        // Back-pressure: output held, no data/cfg acceptance, junk on data_in
        tname = "stall";
        push_abc();
        stall_blk = '0;
        stall_blk[511:480] = 32'h6162_6380;
        stall_blk[63:0]    = 64'd24;
        block_ready = 1'b0;
        cfg32(64'd24);
        word32(32'h6162_6300);
        data_in_valid = 1'b1;
        data_in       = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_blk", block_out, stall_blk);
            check("stall_last", 512'(block_last), 512'(1));
            check("stall_valid", 512'(block_valid), 512'(1));
            check("stall_din_ready", 512'(data_in_ready), 512'(0));
            check("stall_cfg_ready", 512'(cfg_ready), 512'(0));
        end
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        block_ready   = 1'b1;
        wait_drain();

        // Reset after 3 of 16 words: everything discarded
        tname = "rst_mid";
        cfg32(64'd512);
        for (int i = 0; i < 3; i++) word32(32'hFFFF_0000 | i);
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        check("rstmid_valid", 512'(block_valid), 512'(0));
        check("rstmid_last", 512'(block_last), 512'(0));
        check("rstmid_din_ready", 512'(data_in_ready), 512'(0));
        check("rstmid_block_out", block_out, '0);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_cfg_ready", 512'(cfg_ready), 512'(1));
        tname = "after_rst";
        push_abc();
        cfg32(64'd24);
        word32(32'h6162_6300);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
